// File: rtl/vc_router_pkg.sv
// Shared types, constants and helpers for the virtual-channel router blocks.
// Gray codes walk the mod-6 position ring; 010 and 101 are unused codes.
package vc_router_pkg;

    localparam int unsigned NUM_VC   = 6;
    localparam logic [2:0]  LAST_POS = 3'd5;

    localparam logic [2:0] GRAY_P0 = 3'b000;
    localparam logic [2:0] GRAY_P1 = 3'b001;
    localparam logic [2:0] GRAY_P2 = 3'b011;
    localparam logic [2:0] GRAY_P3 = 3'b111;
    localparam logic [2:0] GRAY_P4 = 3'b110;
    localparam logic [2:0] GRAY_P5 = 3'b100;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    function automatic logic [2:0] gray_to_pos(input logic [2:0] g);
        case (g)
            GRAY_P1: return 3'd1;
            GRAY_P2: return 3'd2;
            GRAY_P3: return 3'd3;
            GRAY_P4: return 3'd4;
            GRAY_P5: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] pos_to_gray(input logic [2:0] p);
        case (p)
            3'd1:    return GRAY_P1;
            3'd2:    return GRAY_P2;
            3'd3:    return GRAY_P3;
            3'd4:    return GRAY_P4;
            3'd5:    return GRAY_P5;
            default: return GRAY_P0;
        endcase
    endfunction

    function automatic logic gray_is_legal(input logic [2:0] g);
        return (g != 3'b010) && (g != 3'b101);
    endfunction

    // (p + k) mod 6, for p, k in 0..5
    function automatic logic [2:0] pos_add(input logic [2:0] p, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 4'd6) begin
            s = s - 4'd6;
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/vc_rr_arbiter_if.sv
// Request/grant bundle between the VC input buffers (master) and the arbiter (slave).
interface vc_rr_arbiter_if;
    import vc_router_pkg::*;

    logic [NUM_VC-1:0] req;
    logic [NUM_VC-1:0] tail;
    logic              out_ready;
    logic [NUM_VC-1:0] gnt;
    logic [2:0]        gnt_id;
    logic              flit_fire;
    logic              busy;
    logic [2:0]        ptr_gray;
    logic              ptr_wrap;

    modport master (
        output req, tail, out_ready,
        input  gnt, gnt_id, flit_fire, busy, ptr_gray, ptr_wrap
    );

    modport slave (
        input  req, tail, out_ready,
        output gnt, gnt_id, flit_fire, busy, ptr_gray, ptr_wrap
    );

endinterface

// File: rtl/vc_gray_ptr.sv
// Mod-6 Gray-coded priority pointer: loads (load_idx + 1) mod 6 on advance,
// recovers unused codes to position 0 and toggles ptr_wrap on a 5->0 advance.
module vc_gray_ptr
    import vc_router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic [2:0] load_idx,
    output logic [2:0] ptr_gray,
    output logic [2:0] ptr_pos,
    output logic       ptr_wrap
);

    logic [2:0] gray_q, gray_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        gray_d = gray_q;
        wrap_d = wrap_q;
        // Upset recovery takes precedence over any pending advance
        if (!gray_is_legal(gray_q)) begin
            gray_d = GRAY_P0;
        end else if (advance) begin
            gray_d = pos_to_gray(pos_add(load_idx, 3'd1));
            if (load_idx == LAST_POS) begin
                wrap_d = ~wrap_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_q <= GRAY_P0;
            wrap_q <= 1'b0;
        end else begin
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_gray = gray_q;
    assign ptr_pos  = gray_to_pos(gray_q);
    assign ptr_wrap = wrap_q;

endmodule

// File: rtl/vc_rr_arbiter.sv
// Packet-granular round-robin arbiter for six VCs sharing one output link.
// Define VC_ARB_BURST_LIMIT_EN to cap each grant tenure at BURST_LIMIT flits.
module vc_rr_arbiter
    import vc_router_pkg::*;
#(
    parameter int unsigned BURST_LIMIT = 8
) (
    input logic            clk,
    input logic            reset,
    vc_rr_arbiter_if.slave bus
);

    if (BURST_LIMIT < 1 || BURST_LIMIT > 255) begin : g_bad_burst_limit
        $error("BURST_LIMIT must be in 1..255");
    end

    arb_state_t        state_q, state_d;
    logic [NUM_VC-1:0] gnt_q, gnt_d;
    logic [2:0]        gnt_id_q, gnt_id_d;
    logic [2:0]        ptr_pos;
    logic              advance;
    logic              sel_found;
    logic [2:0]        sel_id;
    logic              fire;
    logic              burst_hit;
    logic              release_now;

    // First requester at or after the pointer position, wrapping mod 6
    always_comb begin
        sel_found = 1'b0;
        sel_id    = 3'd0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (!sel_found && bus.req[pos_add(ptr_pos, 3'(k))]) begin
                sel_found = 1'b1;
                sel_id    = pos_add(ptr_pos, 3'(k));
            end
        end
    end

    assign fire        = (state_q == ARB_GRANT) && bus.req[gnt_id_q] && bus.out_ready;
    assign release_now = fire && (bus.tail[gnt_id_q] || burst_hit);

`ifdef VC_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BurstLast = 8'(BURST_LIMIT - 1);

    logic [7:0] burst_q;
    logic       grant_start;

    assign grant_start = (state_q == ARB_IDLE) && sel_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_q <= 8'd0;
        end else if (grant_start) begin
            burst_q <= 8'd0;
        end else if (fire) begin
            burst_q <= burst_q + 8'd1;
        end
    end

    assign burst_hit = (burst_q == BurstLast);
`else
    assign burst_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        advance  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (sel_found) begin
                    state_d  = ARB_GRANT;
                    gnt_d    = {{(NUM_VC-1){1'b0}}, 1'b1} << sel_id;
                    gnt_id_d = sel_id;
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    state_d  = ARB_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = 3'd0;
                    advance  = 1'b1;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                gnt_d    = '0;
                gnt_id_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    logic [2:0] ptr_gray;
    logic       ptr_wrap;

    vc_gray_ptr u_ptr (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .load_idx (gnt_id_q),
        .ptr_gray (ptr_gray),
        .ptr_pos  (ptr_pos),
        .ptr_wrap (ptr_wrap)
    );

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.flit_fire = fire;
    assign bus.busy      = (state_q == ARB_GRANT);
    assign bus.ptr_gray  = ptr_gray;
    assign bus.ptr_wrap  = ptr_wrap;

endmodule
